// File: rtl/bus_master_burst.sv
// Burst initiator for the shared 8-bit MCU bus: turns local single/burst read and
// write commands into registered bus beats and returns read data on a local stream.
module bus_master_burst #(
    parameter logic [7:0] IDLE_ADDR    = 8'hFF,
    parameter int         READ_LATENCY = 1,
    parameter int         MAX_LEN_W    = 4
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic                 CMD_WRITE,
    input  logic [7:0]           CMD_ADDR,
    input  logic [MAX_LEN_W-1:0] CMD_LEN,
    input  logic [7:0]           WR_DATA,
    input  logic                 WR_VALID,
    output logic                 WR_READY,
    output logic [7:0]           RD_DATA,
    output logic                 RD_VALID,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [7:0]           BUS_ADDR,
    output logic                 BUS_WE,
    inout  wire  [7:0]           BUS_DATA
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_DRAIN = 3'd3,
        S_TURN  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [MAX_LEN_W-1:0] LEN_ONE = MAX_LEN_W'(1);

    state_t                  state_q;
    logic [7:0]              addr_q;
    logic [MAX_LEN_W-1:0]    cnt_q;
    logic [7:0]              bus_addr_q;
    logic                    bus_we_q;
    logic [7:0]              wdata_q;
    logic                    rd_beat_q;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_d;
    logic [7:0]              rd_data_q;
    logic                    rd_valid_q;

    assign CMD_READY = RESETN && (state_q == S_IDLE);
    assign WR_READY  = (state_q == S_WR) && WR_VALID;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = (state_q == S_FIN);
    assign BUS_ADDR  = bus_addr_q;
    assign BUS_WE    = bus_we_q;
    assign BUS_DATA  = bus_we_q ? wdata_q : 8'hzz;
    assign RD_DATA   = rd_data_q;
    assign RD_VALID  = rd_valid_q;

    // Read-tag shift: a tag leaves the last stage when its data is on the bus.
    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = rd_beat_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Control FSM with registered bus outputs and read capture.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= S_IDLE;
            addr_q     <= 8'h00;
            cnt_q      <= '0;
            bus_addr_q <= IDLE_ADDR;
            bus_we_q   <= 1'b0;
            wdata_q    <= 8'h00;
            rd_beat_q  <= 1'b0;
            pipe_q     <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            bus_addr_q <= IDLE_ADDR;
            bus_we_q   <= 1'b0;
            rd_beat_q  <= 1'b0;
            pipe_q     <= pipe_d;
            rd_valid_q <= pipe_q[READ_LATENCY-1];
            if (pipe_q[READ_LATENCY-1]) begin
                rd_data_q <= BUS_DATA;
            end else begin
                rd_data_q <= rd_data_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        addr_q  <= CMD_ADDR;
                        cnt_q   <= CMD_LEN;
                        state_q <= CMD_WRITE ? S_WR : S_RD;
                    end
                end
                S_WR: begin
                    // A cycle without write data leaves the bus idle and the count untouched.
                    if (WR_VALID) begin
                        bus_addr_q <= addr_q;
                        bus_we_q   <= 1'b1;
                        wdata_q    <= WR_DATA;
                        addr_q     <= addr_q + 8'd1;
                        cnt_q      <= cnt_q - LEN_ONE;
                        if (cnt_q == '0) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    bus_addr_q <= addr_q;
                    rd_beat_q  <= 1'b1;
                    addr_q     <= addr_q + 8'd1;
                    cnt_q      <= cnt_q - LEN_ONE;
                    if (cnt_q == '0) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!rd_beat_q && (pipe_q == '0)) begin
                        state_q <= S_TURN;
                    end
                end
                S_TURN:  state_q <= S_FIN;
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_burst.sv
// Directed bench for bus_master_burst with a registered-driver RAM responder on the bus.
module tb_bus_master_burst;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid, wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid, busy, done;
    logic [7:0] bus_addr;
    logic       bus_we;
    wire  [7:0] bus_data;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    bus_master_burst dut (
        .CLK(clk), .RESETN(resetn),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
        .WR_DATA(wr_data), .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .RD_DATA(rd_data), .RD_VALID(rd_valid),
        .BUSY(busy), .DONE(done),
        .BUS_ADDR(bus_addr), .BUS_WE(bus_we), .BUS_DATA(bus_data)
    );

    // RAM responder: one-cycle read latency through a registered driver; 8'hFF is outside its read range.
    logic [7:0] mem [0:255];
    logic       drv_en;
    logic [7:0] drv_data;
    assign bus_data = drv_en ? drv_data : 8'hzz;

    always @(posedge clk) begin
        if (bus_we) mem[bus_addr] <= bus_data;
        drv_en   <= resetn && !bus_we && (bus_addr != 8'hFF);
        drv_data <= mem[bus_addr];
    end

    // Bus monitor: contention count and read/write ordering while armed.
    int cyc = 0;
    int contention = 0;
    logic mon_arm = 1'b0;
    int last_rd_cyc, first_wr_cyc, mon_rv;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus_we && drv_en) contention <= contention + 1;
        if (!mon_arm) begin
            last_rd_cyc  <= -1;
            first_wr_cyc <= -1;
            mon_rv       <= 0;
        end else begin
            if (!bus_we && bus_addr != 8'hFF) last_rd_cyc <= cyc;
            if (bus_we && first_wr_cyc < 0) first_wr_cyc <= cyc;
            if (rd_valid) mon_rv <= mon_rv + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Presents a command and returns just after the accepting edge (first cycle of the burst).
    task automatic send_cmd(input logic w, input logic [7:0] a, input logic [3:0] l);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("cmd accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("returns idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wr_burst(input logic [7:0] a, input logic [3:0] l, input logic [7:0] base);
        int k;
        send_cmd(1'b1, a, l);
        k = 0;
        wr_valid = 1'b1; wr_data = base;
        for (int i = 0; i < 64 && k <= int'(l); i++) begin
            @(negedge clk);
            if (wr_ready) k++;
            @(posedge clk); #1;
            wr_data = base + 8'(k);
        end
        wr_valid = 1'b0;
        chk("write beats consumed", k, int'(l) + 1);
    endtask

    typedef struct {
        logic rn, cv, cw; logic [7:0] ca; logic [3:0] cl; logic wv; logic [7:0] wd;
        logic cr, wr, we; logic [7:0] ba, bd; logic bsy, dn;
    } vec_t;

    function automatic vec_t mk(input logic rn, cv, cw, input logic [7:0] ca, input logic [3:0] cl,
                                input logic wv, input logic [7:0] wd,
                                input logic cr, wr, we, input logic [7:0] ba, bd, input logic bsy, dn);
        vec_t v;
        v.rn = rn; v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd;
        v.cr = cr; v.wr = wr; v.we = we; v.ba = ba; v.bd = bd; v.bsy = bsy; v.dn = dn;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int last_rv, rv_n, done_n, done_c;
        bit ok;
        logic [7:0] exp_ba;
        logic exp_rv;

        resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 4'd0;
        wr_valid = 1'b0; wr_data = 8'h00;

        //            rn  cv  cw  addr  len  wv  wdata   cr  wr  we  bus_a  bus_d  bsy dn
        vecs.push_back(mk(0,0,0,8'h00,4'd0,0,8'h00, 0,0,0,8'hFF,8'h00,0,0)); // in reset
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 1,0,0,8'hFF,8'h00,0,0));
        vecs.push_back(mk(1,1,1,8'h10,4'd0,1,8'hA5, 1,0,0,8'hFF,8'h00,0,0)); // single write
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'hA5, 0,1,0,8'hFF,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'hA5, 0,0,1,8'h10,8'hA5,1,1));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 1,0,0,8'hFF,8'h00,0,0));
        vecs.push_back(mk(1,1,1,8'h7E,4'd3,0,8'h00, 1,0,0,8'hFF,8'h00,0,0)); // burst with gap
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h01, 0,1,0,8'hFF,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h02, 0,1,1,8'h7E,8'h01,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 0,0,1,8'h7F,8'h02,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 0,0,0,8'hFF,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h03, 0,1,0,8'hFF,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h04, 0,1,1,8'h80,8'h03,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 0,0,1,8'h81,8'h04,1,1));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 1,0,0,8'hFF,8'h00,0,0));
        vecs.push_back(mk(1,1,1,8'hFE,4'd3,0,8'h00, 1,0,0,8'hFF,8'h00,0,0)); // address wrap
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h11, 0,1,0,8'hFF,8'h00,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h12, 0,1,1,8'hFE,8'h11,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h13, 0,1,1,8'hFF,8'h12,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,1,8'h14, 0,1,1,8'h00,8'h13,1,0));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 0,0,1,8'h01,8'h14,1,1));
        vecs.push_back(mk(1,0,0,8'h00,4'd0,0,8'h00, 1,0,0,8'hFF,8'h00,0,0));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            resetn = vecs[i].rn; cmd_valid = vecs[i].cv; cmd_write = vecs[i].cw;
            cmd_addr = vecs[i].ca; cmd_len = vecs[i].cl; wr_valid = vecs[i].wv; wr_data = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("row%0d ready/we/addr/busy/done/rdv", i),
                {12'd0, cmd_ready, wr_ready, bus_we, bus_addr, busy, done, rd_valid},
                {12'd0, vecs[i].cr, vecs[i].wr, vecs[i].we, vecs[i].ba, vecs[i].bsy, vecs[i].dn, 1'b0});
            if (vecs[i].we) chk($sformatf("row%0d bus_data", i), {24'd0, bus_data}, {24'd0, vecs[i].bd});
        end
        chk("ram[10] after single write", {24'd0, mem[8'h10]}, 32'hA5);

        // Read burst over RAM 0..7 preloaded with 20..27 through the master itself.
        wr_burst(8'h00, 4'd7, 8'h20);
        wait_idle();
        send_cmd(1'b0, 8'h00, 4'd7);
        last_rv = -1; rv_n = 0; done_n = 0; done_c = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            exp_ba = (c >= 2 && c <= 9) ? 8'(c - 2) : 8'hFF;
            exp_rv = (c >= 4 && c <= 11);
            chk($sformatf("rd c%0d we/addr", c), {23'd0, bus_we, bus_addr}, {23'd0, 1'b0, exp_ba});
            chk($sformatf("rd c%0d rd_valid", c), {31'd0, rd_valid}, {31'd0, exp_rv});
            if (exp_rv) chk($sformatf("rd c%0d rd_data", c), {24'd0, rd_data}, {24'd0, 8'h20 + 8'(c - 4)});
            if (rd_valid) begin last_rv = c; rv_n++; end
            if (done) begin done_n++; done_c = c; end
            @(posedge clk); #1;
        end
        chk("rd valid pulses", rv_n, 8);
        chk("rd done pulses", done_n, 1);
        chk("rd done after turnaround", {31'd0, done_c >= last_rv + 2 && done_c <= last_rv + 3}, 32'd1);

        // Read immediately followed by a write: no contention, idle gap before the write beat.
        mon_arm = 1'b1;
        wr_data = 8'h5A; wr_valid = 1'b1;
        send_cmd(1'b0, 8'h20, 4'd1);
        send_cmd(1'b1, 8'h30, 4'd0);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk("rtw done seen", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rtw read beats returned", mon_rv, 2);
        chk("rtw idle gap", {31'd0, last_rd_cyc >= 0 && first_wr_cyc - last_rd_cyc >= 2}, 32'd1);
        chk("bus contention cycles", contention, 0);
        chk("ram[30] after rtw", {24'd0, mem[8'h30]}, 32'h5A);
        mon_arm = 1'b0;

        // Reset during beat 3 of an 8-beat read.
        send_cmd(1'b0, 8'h40, 4'd7);
        rv_n = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 4) resetn = 1'b0;
            if (c == 6) resetn = 1'b1;
            @(negedge clk);
            if (c == 4) chk("rst beat3 addr", {24'd0, bus_addr}, 32'h42);
            if (c == 5) begin
                chk("rst addr/we/busy/ready", {20'd0, bus_addr, bus_we, busy, cmd_ready, done},
                    {20'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0});
                chk("rst rd_data", {24'd0, rd_data}, 32'h0);
            end
            if (c == 6) chk("rst ready after release", {30'd0, cmd_ready, busy}, {30'd0, 1'b1, 1'b0});
            if (c >= 5 && rd_valid) rv_n++;
            @(posedge clk); #1;
        end
        chk("rst no rd_valid after reset", rv_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
